// File: rtl/prim_ram_2p_bist.sv
// March C- style BIST initiator for one synchronous RAM port: M0 up(w0), M1 up(r0,w1), M2 down(r1,w0), M3 down(r0).
// Define PRIM_RAM_BIST_STOP_ON_FAIL_EN to end the test on the first read mismatch.
module prim_ram_2p_bist #(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [7:0]       err_cnt_o,
  output logic [Aw-1:0]    fail_addr_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1_RD,
    ST_M1_WR,
    ST_M2_RD,
    ST_M2_WR,
    ST_M3_RD,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  localparam logic [Aw-1:0] AddrOne  = Aw'(1);

  state_e          state_q, state_d;
  logic [Aw-1:0]   addr_q, addr_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_exp_q, rd_exp_d;
  logic [Aw-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [Aw-1:0]   fail_addr_q, fail_addr_d;

  logic            mismatch;
  logic            stop_now;
  logic            is_rd;

  // Compare the word requested last cycle against the background it should hold.
  assign mismatch = rd_pend_q && (ram_rdata_i != {Width{rd_exp_q}});

`ifdef PRIM_RAM_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch && (err_cnt_q == 8'd0);
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    rd_exp_d    = rd_exp_q;
    rd_addr_d   = addr_q;
    is_rd       = 1'b0;

    if (mismatch) begin
      if (err_cnt_q != 8'hff) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (err_cnt_q == 8'd0) begin
        fail_addr_d = rd_addr_q;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_M0;
          addr_d      = '0;
          err_cnt_d   = 8'd0;
          fail_addr_d = '0;
        end
      end
      ST_M0: begin
        if (addr_q == LastAddr) begin
          state_d = ST_M1_RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AddrOne;
        end
      end
      ST_M1_RD: begin
        is_rd    = 1'b1;
        rd_exp_d = 1'b0;
        state_d  = ST_M1_WR;
      end
      ST_M1_WR: begin
        if (addr_q == LastAddr) begin
          state_d = ST_M2_RD;
        end else begin
          state_d = ST_M1_RD;
          addr_d  = addr_q + AddrOne;
        end
      end
      ST_M2_RD: begin
        is_rd    = 1'b1;
        rd_exp_d = 1'b1;
        state_d  = ST_M2_WR;
      end
      ST_M2_WR: begin
        if (addr_q == '0) begin
          state_d = ST_M3_RD;
          addr_d  = LastAddr;
        end else begin
          state_d = ST_M2_RD;
          addr_d  = addr_q - AddrOne;
        end
      end
      ST_M3_RD: begin
        is_rd    = 1'b1;
        rd_exp_d = 1'b0;
        if (addr_q == '0) begin
          state_d = ST_FLUSH;
        end else begin
          addr_d = addr_q - AddrOne;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An early stop abandons any read in flight so DONE never compares.
    if (stop_now) begin
      state_d = ST_DONE;
    end
    rd_pend_d = is_rd && !stop_now;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= 1'b0;
      rd_addr_q   <= '0;
      err_cnt_q   <= 8'd0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  // RAM port and status decode straight from state so reset clears them in the same cycle.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_wdata_o = '0;
    unique case (state_q)
      ST_M0, ST_M2_WR: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
      end
      ST_M1_WR: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_wdata_o = '1;
      end
      ST_M1_RD, ST_M2_RD, ST_M3_RD: begin
        ram_req_o = 1'b1;
      end
      default: begin
        ram_req_o = 1'b0;
      end
    endcase
  end

  assign ram_addr_o  = ram_req_o ? addr_q : '0;
  assign ram_wmask_o = ram_write_o ? '1 : '0;

  assign busy_o      = ram_req_o || (state_q == ST_FLUSH);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = done_o && (err_cnt_q == 8'd0);
  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;

endmodule
